// File: rtl/gps_iq_collector.sv
// Collects serial IQ accumulator dumps from GPS correlator channels and presents each
// INTEG_BITS-wide field as a parallel word on a valid/ready port, round-robin over channels.
module gps_iq_collector #(
  parameter int unsigned NCHAN      = 12,
  parameter int unsigned INTEG_BITS = 20,
  parameter int unsigned E1B        = 0,
  localparam int unsigned NFIELDS   = (E1B != 0) ? 12 : 6,
  localparam int unsigned CW        = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int unsigned FW        = $clog2(NFIELDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCHAN-1:0]      epoch,
  input  logic [NCHAN-1:0]      sout,
  output logic [NCHAN-1:0]      shift,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [INTEG_BITS-1:0] rd_data,
  output logic [CW-1:0]         rd_chan,
  output logic [FW-1:0]         rd_field,
  output logic                  rd_last,
  output logic                  rd_ovf,
  output logic [NCHAN-1:0]      missed,
  input  logic                  clr_missed
);

  localparam int unsigned BW = (INTEG_BITS > 1) ? $clog2(INTEG_BITS) : 1;
  localparam logic [BW-1:0] BitLast   = BW'(INTEG_BITS - 1);
  localparam logic [FW-1:0] FieldLast = FW'(NFIELDS - 1);
  localparam logic [CW-1:0] ChanLast  = CW'(NCHAN - 1);

  typedef enum logic [1:0] {StIdle, StShift, StOut} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         sel_q, sel_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]         field_q, field_d;
  logic [INTEG_BITS-1:0] word_q, word_d;
  logic                  ovf_q, ovf_d;
  logic [NCHAN-1:0]      pending_q, pending_d;
  logic [NCHAN-1:0]      missed_q, missed_d;
  logic [NCHAN-1:0]      shift_q, shift_d;
  logic [NCHAN-1:0]      clr_pend;

  logic          found;
  logic [CW-1:0] pick;
  int unsigned   idx;

  // Round-robin search: first pending channel at or after rr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NCHAN; k++) begin
      idx = (32'(rr_q) + k) % NCHAN;
      if (!found && pending_q[idx[CW-1:0]]) begin
        found = 1'b1;
        pick  = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    bit_cnt_d = bit_cnt_q;
    field_d   = field_q;
    word_d    = word_q;
    ovf_d     = ovf_q;
    shift_d   = '0;
    clr_pend  = '0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          sel_d          = pick;
          clr_pend[pick] = 1'b1;
          ovf_d          = 1'b0;
          bit_cnt_d      = '0;
          field_d        = '0;
          rr_d           = (pick == ChanLast) ? '0 : pick + CW'(1);
          shift_d[pick]  = 1'b1;
          state_d        = StShift;
        end
      end
      StShift: begin
        word_d = {word_q[INTEG_BITS-2:0], sout[sel_q]};
        if (bit_cnt_q == BitLast) begin
          state_d = StOut;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          shift_d   = shift_q;
        end
      end
      StOut: begin
        if (rd_ready) begin
          if (field_q == FieldLast) begin
            state_d = StIdle;
          end else begin
            field_d        = field_q + FW'(1);
            bit_cnt_d      = '0;
            shift_d[sel_q] = 1'b1;
            state_d        = StShift;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new epoch on the channel being read reloads its register mid-dump.
    if (state_q != StIdle && epoch[sel_q]) begin
      ovf_d = 1'b1;
    end

    pending_d = (pending_q & ~clr_pend) | epoch;
    missed_d  = (clr_missed ? '0 : missed_q) | (epoch & pending_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      rr_q      <= '0;
      bit_cnt_q <= '0;
      field_q   <= '0;
      word_q    <= '0;
      ovf_q     <= 1'b0;
      pending_q <= '0;
      missed_q  <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      bit_cnt_q <= bit_cnt_d;
      field_q   <= field_d;
      word_q    <= word_d;
      ovf_q     <= ovf_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
      shift_q   <= shift_d;
    end
  end

  assign shift    = shift_q;
  assign rd_valid = (state_q == StOut);
  assign rd_data  = word_q;
  assign rd_chan  = sel_q;
  assign rd_field = field_q;
  assign rd_last  = rd_valid && (field_q == FieldLast);
  assign rd_ovf   = rd_valid && ovf_q;
  assign missed   = missed_q;

endmodule
